// File: rtl/scarv_cop_palu_dispatch.sv
// ---------------------------------------------------------------------------
// scarv_cop_palu_dispatch
//
// Issue side of the PALU ivalid/idone handshake. Accepts one decoded PALU
// instruction at a time and holds its operands stable towards the PALU. It
// then waits for palu_idone (single-cycle op or multi-cycle multiply) or a
// timeout. The result is committed into the CPR write port as a one-cycle
// pulse, and a status response goes back to the coprocessor front end.
//
// Handshakes:
//   id_valid/id_ready and rsp_valid/rsp_ready are strict valid/ready pairs.
//   A transfer happens on a rising edge where both are high. A producer keeps
//   valid and its payload stable until that edge, and never withdraws valid.
//   palu_ivalid/palu_idone is a request/complete pair. The request is held,
//   with constant operands, until completion or timeout.
//
// Ports:
//   g_clk, g_resetn        clock, synchronous active-low reset
//   id_*                   decoded instruction + operands, id_ready back
//   palu_*  (out)          latched instruction/operands + palu_ivalid
//   palu_idone, palu_cpr_* PALU completion, byte enables and result
//   cpr_wen/waddr/wdata    CPR write port (wen is a 1-cycle pulse)
//   rsp_valid/ready/status response: 0 written, 1 no write, 2 timeout
//   dbg_state              current FSM state (0 IDLE, 1 EXEC, 2 RESP)
// ---------------------------------------------------------------------------
module scarv_cop_palu_dispatch #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [2:0]  id_class,
  input  logic [4:0]  id_subclass,
  input  logic [2:0]  id_pw,
  input  logic [31:0] id_imm,
  input  logic [3:0]  id_crd,
  input  logic [31:0] id_gpr_rs1,
  input  logic [31:0] id_rs1,
  input  logic [31:0] id_rs2,
  input  logic [31:0] id_rs3,
  output logic        palu_ivalid,
  output logic [2:0]  palu_id_class,
  output logic [4:0]  palu_id_subclass,
  output logic [2:0]  palu_id_pw,
  output logic [31:0] palu_id_imm,
  output logic [31:0] palu_gpr_rs1,
  output logic [31:0] palu_rs1,
  output logic [31:0] palu_rs2,
  output logic [31:0] palu_rs3,
  input  logic        palu_idone,
  input  logic [3:0]  palu_cpr_rd_ben,
  input  logic [31:0] palu_cpr_rd_wdata,
  output logic [3:0]  cpr_wen,
  output logic [3:0]  cpr_waddr,
  output logic [31:0] cpr_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_status,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] CNT_MAX  = 8'(TIMEOUT);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_d;
  logic        ivalid_q;
  logic [2:0]  class_q;
  logic [4:0]  subclass_q;
  logic [2:0]  pw_q;
  logic [31:0] imm_q;
  logic [3:0]  crd_q;
  logic [31:0] gpr_rs1_q;
  logic [31:0] rs1_q;
  logic [31:0] rs2_q;
  logic [31:0] rs3_q;
  logic [3:0]  wen_q;
  logic [3:0]  waddr_q;
  logic [31:0] wdata_q;
  logic        rsp_valid_q;
  logic [1:0]  rsp_status_q;

  // Cycle counter saturates rather than wrapping, so a stuck PALU can never
  // alias back to a small count.
  assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;

  // Combinational gate on reset so nothing is accepted while held in reset.
  assign id_ready = g_resetn && (state_q == ST_IDLE);

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ivalid_q     <= 1'b0;
      class_q      <= '0;
      subclass_q   <= '0;
      pw_q         <= '0;
      imm_q        <= '0;
      crd_q        <= '0;
      gpr_rs1_q    <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rs3_q        <= '0;
      wen_q        <= '0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= '0;
    end else begin
      // Write enable is a single-cycle pulse by default.
      wen_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (id_valid && id_ready) begin
            class_q    <= id_class;
            subclass_q <= id_subclass;
            pw_q       <= id_pw;
            imm_q      <= id_imm;
            crd_q      <= id_crd;
            gpr_rs1_q  <= id_gpr_rs1;
            rs1_q      <= id_rs1;
            rs2_q      <= id_rs2;
            rs3_q      <= id_rs3;
            cnt_q      <= '0;
            ivalid_q   <= 1'b1;
            state_q    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Completion takes priority over a timeout on the same edge.
          if (palu_idone) begin
            wen_q        <= palu_cpr_rd_ben;
            wdata_q      <= palu_cpr_rd_wdata;
            waddr_q      <= crd_q;
            rsp_status_q <= (palu_cpr_rd_ben != 4'd0) ? 2'd0 : 2'd1;
            rsp_valid_q  <= 1'b1;
            ivalid_q     <= 1'b0;
            state_q      <= ST_RESP;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_q == CNT_LAST) begin
              rsp_status_q <= 2'd2;
              rsp_valid_q  <= 1'b1;
              ivalid_q     <= 1'b0;
              state_q      <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign palu_ivalid      = ivalid_q;
  assign palu_id_class    = class_q;
  assign palu_id_subclass = subclass_q;
  assign palu_id_pw       = pw_q;
  assign palu_id_imm      = imm_q;
  assign palu_gpr_rs1     = gpr_rs1_q;
  assign palu_rs1         = rs1_q;
  assign palu_rs2         = rs2_q;
  assign palu_rs3         = rs3_q;
  assign cpr_wen          = wen_q;
  assign cpr_waddr        = waddr_q;
  assign cpr_wdata        = wdata_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_status       = rsp_status_q;
  assign dbg_state        = state_q;

endmodule
